// File: rtl/byte_serial_adder32_pkg.sv
// Shared ALU definitions: FSM state encoding, slice width and operation codes
// used by the byte-serial adder.
package byte_serial_adder32_pkg;

    localparam int SLICE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serial_adder32_add.sv
// 8-bit carry-lookahead slice: generate/propagate per bit, carries from the
// lookahead recurrence, purely combinational.
module ADD (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] z,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // c[i+1] = g[i] | p[i]&c[i], unrolled by synthesis into two-level lookahead
    always_comb begin
        g = x & y;
        p = x ^ y;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        z    = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/byte_serial_adder32.sv
// Multi-cycle add/subtract: one shared 8-bit slice walks the operands LSB byte
// first, carry registered between bytes, flags captured with the last byte.
module byte_serial_adder32
    import byte_serial_adder32_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    op_sub,
    input  logic [8*NBYTES-1:0]     a,
    input  logic [8*NBYTES-1:0]     b,
    output logic                    busy,
    output logic                    done,
    output logic [8*NBYTES-1:0]     sum,
    output logic                    carry,
    output logic                    overflow,
    output logic                    zero,
    output logic                    sign
);

    localparam int W    = SLICE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t state;
    state_t next_state;

    logic [W-1:0]       opa;
    logic [W-1:0]       opb;
    logic               cr;
    logic [IDXW-1:0]    idx;
    logic [SLICE_W-1:0] slice_x;
    logic [SLICE_W-1:0] slice_y;
    logic [SLICE_W-1:0] slice_z;
    logic               slice_cout;
    logic [W-1:0]       sum_next;
    logic               accept;
    logic               last_byte;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_byte = (idx == IDXW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start arriving while DONE is shown chains straight into the next RUN
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_byte) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_comb begin
        slice_x  = opa[idx*SLICE_W +: SLICE_W];
        slice_y  = opb[idx*SLICE_W +: SLICE_W];
        sum_next = sum;
        sum_next[idx*SLICE_W +: SLICE_W] = slice_z;
    end

    ADD u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (cr),
        .z    (slice_z),
        .cout (slice_cout)
    );

    // Subtraction is a + ~b + 1: the +1 rides in as the carry into byte 0
    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            cr       <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            sign     <= 1'b0;
        end else if (accept) begin
            opa <= a;
            opb <= (op_sub == OP_SUB) ? ~b : b;
            cr  <= op_sub;
            idx <= '0;
        end else if (state == RUN) begin
            sum <= sum_next;
            cr  <= slice_cout;
            idx <= idx + 1'b1;
            if (last_byte) begin
                carry    <= slice_cout;
                overflow <= (opa[W-1] == opb[W-1]) && (slice_z[SLICE_W-1] != opa[W-1]);
                zero     <= (sum_next == '0);
                sign     <= slice_z[SLICE_W-1];
            end
        end
    end

endmodule

// File: tb/tb_byte_serial_adder32.sv
// Scoreboard bench for byte_serial_adder32: directed vectors push expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_byte_serial_adder32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        sign;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        overflow;
        logic        zero;
        logic        sign;
        int          doneCycle;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    byte_serial_adder32 #(.NBYTES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .sign     (sign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start with operands and records the hand-computed result;
    // the caller owns how long start stays high.
    task automatic applyStimulus(input logic sub, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] expSum, input logic expC, input logic expV,
                                 input logic expZ, input logic expS);
        exp_t e;
        start  = 1'b1;
        op_sub = sub;
        a      = av;
        b      = bv;
        e.sum       = expSum;
        e.carry     = expC;
        e.overflow  = expV;
        e.zero      = expZ;
        e.sign      = expS;
        e.doneCycle = cyc + 5;
        sb.push_back(e);
    endtask

    task automatic runOne(input logic sub, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] expSum, input logic expC, input logic expV,
                          input logic expZ, input logic expS);
        applyStimulus(sub, av, bv, expSum, expC, expV, expZ, expS);
        tick(1);
        start = 1'b0;
        checkOutput("busyInRun", {31'b0, busy}, 32'd1);
        tick(6);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, required no done", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sum", sum, e.sum);
                    checkOutput("carry", {31'b0, carry}, {31'b0, e.carry});
                    checkOutput("overflow", {31'b0, overflow}, {31'b0, e.overflow});
                    checkOutput("zero", {31'b0, zero}, {31'b0, e.zero});
                    checkOutput("sign", {31'b0, sign}, {31'b0, e.sign});
                    checkOutput("latency", 32'(cyc), 32'(e.doneCycle));
                    checkOutput("busyWithDone", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        tick(3);
        @(negedge clk);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetSum", sum, 32'd0);
        checkOutput("resetFlags", {28'b0, carry, overflow, zero, sign}, 32'd0);
        rst = 1'b0;
        tick(2);

        runOne(1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        runOne(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        runOne(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        runOne(1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        runOne(1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // start held through RUN with operands changed after acceptance
        applyStimulus(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        a      = 32'hFFFF_FFFF;
        b      = 32'hFFFF_FFFF;
        op_sub = 1'b1;
        tick(4);
        start = 1'b0;
        tick(3);

        // back-to-back: second start lands in the DONE cycle of the first
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        start = 1'b0;
        tick(4);
        checkOutput("doneBeforeChain", {31'b0, done}, 32'd1);
        applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        start = 1'b0;
        checkOutput("chainBusy", {31'b0, busy}, 32'd1);
        tick(6);

        runOne(1'b1, 32'h0100_0000, 32'h0000_0001, 32'h00FF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset during cycle 2 of an operation aborts it with no done pulse
        start  = 1'b1;
        op_sub = 1'b0;
        a      = 32'h0101_0101;
        b      = 32'h0202_0202;
        tick(1);
        start = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortDone", {31'b0, done}, 32'd0);
        checkOutput("abortSum", sum, 32'd0);
        checkOutput("abortFlags", {28'b0, carry, overflow, zero, sign}, 32'd0);
        rst = 1'b0;
        tick(10);

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drainTimeout: got %0d results pending, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
